// File: rtl/csa_result_checker.sv
// Run-based result checker for a WIDTH-bit adder: compares {co,s} with a+b+ci for
// NUM_VECTORS vectors and reports vector/error counts, first failing index and pass.
//
// state | meaning
// IDLE  | waiting for start, no vectors accepted
// RUN   | accepting vectors, one per cycle while vec_valid is high
// DONE  | run complete, results held until the next start
module csa_result_checker #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned NUM_VECTORS = 512
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             vec_valid,
   output logic             vec_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic [WIDTH-1:0] s,
   input  logic             co,
   output logic             mismatch,
   output logic [15:0]      vec_cnt,
   output logic [15:0]      err_cnt,
   output logic [15:0]      first_fail_idx,
   output logic             done,
   output logic             pass
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
   localparam logic [15:0] NO_FAIL  = 16'hFFFF;

   state_t         state_q;
   logic           mismatch_q;
   logic           done_q;
   logic           pass_q;
   logic [15:0]    vec_cnt_q;
   logic [15:0]    err_cnt_q;
   logic [15:0]    first_fail_q;

   logic [WIDTH:0] expected;
   logic [WIDTH:0] observed;
   logic           miscompare;
   logic           accept;
   logic [15:0]    vec_cnt_d;
   logic [15:0]    err_cnt_d;

   always_comb begin
      expected   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
      observed   = {co, s};
      miscompare = (observed != expected);
      accept     = vec_valid && vec_ready;
      vec_cnt_d  = vec_cnt_q + 16'd1;
      err_cnt_d  = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
   end

   assign vec_ready = (state_q == RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         mismatch_q   <= 1'b0;
         vec_cnt_q    <= 16'd0;
         err_cnt_q    <= 16'd0;
         first_fail_q <= NO_FAIL;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         mismatch_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q      <= RUN;
                  vec_cnt_q    <= 16'd0;
                  err_cnt_q    <= 16'd0;
                  first_fail_q <= NO_FAIL;
                  done_q       <= 1'b0;
                  pass_q       <= 1'b0;
               end
            end
            RUN: begin
               if (accept) begin
                  vec_cnt_q <= vec_cnt_d;
                  if (miscompare) begin
                     mismatch_q <= 1'b1;
                     err_cnt_q  <= err_cnt_d;
                     // err_cnt saturates, so zero reliably means no failure yet
                     if (err_cnt_q == 16'd0) begin
                        first_fail_q <= vec_cnt_q;
                     end
                  end
                  if (vec_cnt_q == LAST_IDX) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     pass_q  <= (err_cnt_q == 16'd0) && !miscompare;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mismatch       = mismatch_q;
   assign vec_cnt        = vec_cnt_q;
   assign err_cnt        = err_cnt_q;
   assign first_fail_idx = first_fail_q;
   assign done           = done_q;
   assign pass           = pass_q;

endmodule

// File: tb/tb_csa_result_checker.sv
// Self-checking bench for csa_result_checker: directed runs, a vector table and
// randomized traffic, all compared against a run-level reference model.
module tb_csa_result_checker;

   localparam int NV = 512;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        vec_valid;
   logic        vec_ready;
   logic [3:0]  a;
   logic [3:0]  b;
   logic        ci;
   logic [3:0]  s;
   logic        co;
   logic        mismatch;
   logic [15:0] vec_cnt;
   logic [15:0] err_cnt;
   logic [15:0] first_fail_idx;
   logic        done;
   logic        pass;

   csa_result_checker #(.WIDTH(4), .NUM_VECTORS(NV)) dut (
      .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec_ready(vec_ready),
      .a(a), .b(b), .ci(ci), .s(s), .co(co), .mismatch(mismatch), .vec_cnt(vec_cnt),
      .err_cnt(err_cnt), .first_fail_idx(first_fail_idx), .done(done), .pass(pass)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   // reference model: run phase, counts and flags as plain integers
   bit m_running, m_finished;
   int m_vec, m_err, m_first;
   bit m_mis, m_pass;

   typedef struct {
      logic [3:0] a;
      logic [3:0] b;
      logic       ci;
      logic [3:0] s;
      logic       co;
      logic       exp_mis;
   } tv_t;
   tv_t tbl[8];

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
      else n_pass++;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_total++;
      if (act !== exp) $display("FAIL %s actual=%b required=%b", name, act, exp);
      else n_pass++;
   endtask

   task automatic model_reset();
      m_running = 0; m_finished = 0;
      m_vec = 0; m_err = 0; m_first = 65535;
      m_mis = 0; m_pass = 0;
   endtask

   task automatic model_edge();
      int sum, got;
      m_mis = 0;
      if (!m_running) begin
         if (start) begin
            m_running = 1; m_finished = 0;
            m_vec = 0; m_err = 0; m_first = 65535; m_pass = 0;
         end
      end else if (vec_valid) begin
         sum = int'(a) + int'(b) + int'(ci);
         got = int'(co) * 16 + int'(s);
         if (sum != got) begin
            m_mis = 1;
            if (m_first == 65535) m_first = m_vec;
            if (m_err < 65535) m_err++;
         end
         m_vec++;
         if (m_vec == NV) begin
            m_running = 0; m_finished = 1; m_pass = (m_err == 0);
         end
      end
   endtask

   task automatic check_all();
      chk1 ("vec_ready", vec_ready, m_running);
      chk1 ("mismatch", mismatch, m_mis);
      chk16("vec_cnt", vec_cnt, 16'(m_vec));
      chk16("err_cnt", err_cnt, 16'(m_err));
      chk16("first_fail_idx", first_fail_idx, 16'(m_first));
      chk1 ("done", done, m_finished);
      chk1 ("pass", pass, m_finished && m_pass);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic drive(input logic v, input logic [3:0] ta, input logic [3:0] tb_,
                        input logic tci, input logic [3:0] ts, input logic tco);
      vec_valid = v; a = ta; b = tb_; ci = tci; s = ts; co = tco;
   endtask

   task automatic drive_good(input logic v, input logic [3:0] ta, input logic [3:0] tb_,
                             input logic tci);
      int sum;
      logic [4:0] r;
      sum = int'(ta) + int'(tb_) + int'(tci);
      r = 5'(sum);
      drive(v, ta, tb_, tci, r[3:0], r[4]);
   endtask

   task automatic drive_rand(input bit allow_bad);
      logic [3:0] ta, tb_;
      logic       tci;
      logic [4:0] r;
      int sum;
      ta  = 4'($urandom_range(0, 15));
      tb_ = 4'($urandom_range(0, 15));
      tci = 1'($urandom_range(0, 1));
      sum = int'(ta) + int'(tb_) + int'(tci);
      r = 5'(sum);
      if (allow_bad && $urandom_range(0, 7) == 0) r = r ^ 5'($urandom_range(1, 31));
      drive(1'b1, ta, tb_, tci, r[3:0], r[4]);
   endtask

   task automatic run_exhaustive(input int bad_idx);
      logic [8:0] idx;
      for (int i = 0; i < NV; i++) begin
         idx = 9'(i);
         if (i == bad_idx) drive(1'b1, idx[8:5], idx[4:1], idx[0], 4'h5, 1'b0);
         else drive_good(1'b1, idx[8:5], idx[4:1], idx[0]);
         tick();
         if (i == bad_idx) chk1("vec7_mismatch_pulse", mismatch, 1'b1);
      end
      drive(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
   endtask

   initial begin
      int guard;
      tbl[0] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
      tbl[1] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b0, 1'b1};
      tbl[2] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0};
      tbl[3] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b0};
      tbl[4] = '{4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b0};
      tbl[5] = '{4'h7, 4'h8, 1'b1, 4'hF, 1'b0, 1'b1};
      tbl[6] = '{4'hA, 4'h5, 1'b0, 4'hF, 1'b0, 1'b0};
      tbl[7] = '{4'h3, 4'h3, 1'b0, 4'h7, 1'b0, 1'b1};

      rst = 1'b1; start = 1'b0;
      drive(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      rst = 1'b0;
      tick();

      // correct adder, exhaustive inputs
      start = 1'b1; tick(); start = 1'b0;
      run_exhaustive(-1);
      chk1 ("run1_done", done, 1'b1);
      chk1 ("run1_pass", pass, 1'b1);
      chk16("run1_vec_cnt", vec_cnt, 16'd512);
      chk16("run1_err_cnt", err_cnt, 16'd0);
      chk16("run1_first_fail", first_fail_idx, 16'hFFFF);

      // vector 7 corrupted (a=0,b=3,ci=1 reported as s=5)
      start = 1'b1; tick(); start = 1'b0;
      run_exhaustive(7);
      chk16("run2_err_cnt", err_cnt, 16'd1);
      chk16("run2_first_fail", first_fail_idx, 16'd7);
      chk1 ("run2_pass", pass, 1'b0);
      chk1 ("run2_done", done, 1'b1);

      // restart from a failing DONE
      start = 1'b1; tick(); start = 1'b0;
      chk16("restart_err_cnt", err_cnt, 16'd0);
      chk16("restart_first_fail", first_fail_idx, 16'hFFFF);
      chk1 ("restart_done", done, 1'b0);

      for (int k = 0; k < 8; k++) begin
         drive(1'b1, tbl[k].a, tbl[k].b, tbl[k].ci, tbl[k].s, tbl[k].co);
         tick();
         chk1("tbl_mismatch", mismatch, tbl[k].exp_mis);
      end
      chk16("tbl_err_cnt", err_cnt, 16'd3);
      chk16("tbl_first_fail", first_fail_idx, 16'd1);

      // five-cycle stall with a start pulse inside it
      for (int k = 0; k < 5; k++) begin
         drive_rand(1'b0);
         vec_valid = 1'b0;
         start = (k == 2);
         tick();
      end
      start = 1'b0;
      chk16("stall_hold", vec_cnt, 16'd8);

      guard = 0;
      while (m_running && guard < 5000) begin
         drive_rand(1'b1);
         vec_valid = ($urandom_range(0, 3) != 0);
         start = ($urandom_range(0, 15) == 0);
         tick();
         guard++;
      end
      start = 1'b0;
      chk1 ("rand_run_done", done, 1'b1);
      chk16("rand_run_vec_cnt", vec_cnt, 16'd512);

      // vectors offered in DONE must be ignored
      for (int k = 0; k < 4; k++) begin
         drive_rand(1'b1);
         tick();
      end

      // asynchronous reset after 100 vectors
      start = 1'b1; vec_valid = 1'b0; tick(); start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         drive_rand(1'b1);
         tick();
      end
      drive_rand(1'b1);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      chk16("async_rst_vec_cnt", vec_cnt, 16'd0);
      chk1 ("async_rst_ready", vec_ready, 1'b0);
      tick();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_rand(1'b1);
         tick();
      end
      start = 1'b1; vec_valid = 1'b0; tick(); start = 1'b0;
      guard = 0;
      while (m_running && guard < 2000) begin
         drive_rand(1'b1);
         tick();
         guard++;
      end
      chk1 ("post_rst_done", done, 1'b1);
      chk16("post_rst_vec_cnt", vec_cnt, 16'd512);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
